// File: rtl/mp_register_file_if.sv
// Bus bundle for mp_register_file: read ports, write/reservation controls and
// the register-dump stream. Widths follow the register-file parameters.
interface mp_register_file_if #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2
);
  localparam int AW = $clog2(NUM_REGS);

  logic [NUM_RD*AW-1:0]     rs;
  logic [NUM_RD*DATA_W-1:0] readData;
  logic [NUM_RD-1:0]        busy;
  logic                     RegWrite;
  logic [AW-1:0]            wr_addr;
  logic [DATA_W-1:0]        WriteData;
  logic                     resv_en;
  logic [AW-1:0]            resv_addr;
  logic                     dump_start;
  logic                     dump_valid;
  logic                     dump_ready;
  logic [AW-1:0]            dump_addr;
  logic [DATA_W-1:0]        dump_data;
  logic                     dump_done;

  // Dump handshake: a beat transfers on a rising clk where dump_valid and
  // dump_ready are both 1; while dump_valid=1 and dump_ready=0 the producer
  // holds dump_addr, and dump_valid never drops until the beat is taken.
  modport master (
    output rs, RegWrite, wr_addr, WriteData, resv_en, resv_addr,
           dump_start, dump_ready,
    input  readData, busy, dump_valid, dump_addr, dump_data, dump_done
  );

  modport slave (
    input  rs, RegWrite, wr_addr, WriteData, resv_en, resv_addr,
           dump_start, dump_ready,
    output readData, busy, dump_valid, dump_addr, dump_data, dump_done
  );
endinterface

// File: rtl/mp_register_file.sv
// Multi-read-port register file with write bypass, per-register pending
// (reservation) bits and a valid/ready sequential dump of all registers.
module mp_register_file #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2,
  parameter int ZERO_R0  = 1
) (
  input  logic                clk,
  input  logic                rst,
  mp_register_file_if.slave   bus,
  output logic [1:0]          dbg_state_o
);
  localparam int AW = $clog2(NUM_REGS);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
  } dump_state_e;

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] pend_q, pend_d;
  dump_state_e         state_q, state_d;
  logic [AW-1:0]       idx_q, idx_d;
  logic                wr_en;

  assign wr_en = bus.RegWrite && !((ZERO_R0 != 0) && (bus.wr_addr == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < NUM_REGS; j++) regs_q[j] <= '0;
    end else if (wr_en) begin
      regs_q[bus.wr_addr] <= bus.WriteData;
    end
  end

  // Set is applied after clear so a same-address reservation wins.
  always_comb begin
    pend_d = pend_q;
    if (bus.RegWrite) pend_d[bus.wr_addr] = 1'b0;
    if (bus.resv_en) pend_d[bus.resv_addr] = 1'b1;
    if (ZERO_R0 != 0) pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend_q <= '0;
    else     pend_q <= pend_d;
  end

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [AW-1:0] ra;
    logic          r0_hit;
    logic          wr_hit;
    assign ra     = bus.rs[gi*AW +: AW];
    assign r0_hit = (ZERO_R0 != 0) && (ra == '0);
    assign wr_hit = bus.RegWrite && (bus.wr_addr == ra);
    assign bus.readData[gi*DATA_W +: DATA_W] =
      r0_hit ? '0 : ((wr_en && wr_hit) ? bus.WriteData : regs_q[ra]);
    assign bus.busy[gi] = pend_q[ra] && !wr_hit;
  end

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    bus.dump_valid = 1'b0;
    bus.dump_done  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.dump_start) begin
          state_d = S_STREAM;
          idx_d   = '0;
        end
      end
      S_STREAM: begin
        bus.dump_valid = 1'b1;
        if (bus.dump_ready) begin
          if (idx_q == AW'(NUM_REGS - 1)) state_d = S_DONE;
          else                            idx_d   = idx_q + AW'(1);
        end
      end
      S_DONE: begin
        bus.dump_done = 1'b1;
        state_d       = S_IDLE;
        idx_d         = '0;
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Dump data is the stored value only; in-flight writes show up a cycle later.
  assign bus.dump_addr = idx_q;
  assign bus.dump_data = (state_q == S_STREAM) ? regs_q[idx_q] : '0;
  assign dbg_state_o   = state_q;
endmodule
